// File: rtl/formula_checker_pkg.sv
// Shared constants, FSM state type and arithmetic width helpers for the
// sequential formula checker.
package formula_checker_pkg;

    // 2-bit boolean literal codes; 00 and 01 both mean "variable absent"
    localparam logic [1:0] BOOL_ABSENT   = 2'b00;
    localparam logic [1:0] BOOL_RESERVED = 2'b01;
    localparam logic [1:0] BOOL_POS      = 2'b10;
    localparam logic [1:0] BOOL_NEG      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int prod_width(input int coef_w, input int var_w);
        return coef_w + var_w;
    endfunction

    // Wide enough for NI products plus the bias without overflow
    function automatic int sum_width(input int coef_w, input int var_w, input int idx_w);
        return coef_w + var_w + idx_w + 1;
    endfunction

endpackage

// File: rtl/formula_checker_seq_clause_evaluator.sv
// Combinational evaluation of one mixed integer/boolean clause:
// (sum coef_i*x_i + bias <= 0) OR any present boolean literal.
module clause_evaluator
    import formula_checker_pkg::*;
#(
    parameter int INT_COEF_W     = 4,
    parameter int INT_VAR_IDX_W  = 1,
    parameter int BOOL_VAR_IDX_W = 1,
    parameter int INT_VAR_W      = 4
) (
    input  logic [((1 << INT_VAR_IDX_W) + 1) * INT_COEF_W - 1:0] coefs_int,
    input  logic [2 * (1 << BOOL_VAR_IDX_W) - 1:0]               coefs_bool,
    input  logic [(1 << INT_VAR_IDX_W) * INT_VAR_W - 1:0]        ints,
    input  logic [(1 << BOOL_VAR_IDX_W) - 1:0]                   bools,
    output logic                                                 satisfied
);

    localparam int NI     = 1 << INT_VAR_IDX_W;
    localparam int NB     = 1 << BOOL_VAR_IDX_W;
    localparam int PROD_W = prod_width(INT_COEF_W, INT_VAR_W);
    localparam int SUM_W  = sum_width(INT_COEF_W, INT_VAR_W, INT_VAR_IDX_W);

    logic signed [INT_COEF_W-1:0] coef;
    logic signed [INT_VAR_W-1:0]  xval;
    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      sum;
    logic [1:0]                   code;
    logic                         bool_true;
    logic                         int_true;

    always_comb begin
        coef = coefs_int[NI*INT_COEF_W +: INT_COEF_W];
        xval = '0;
        prod = '0;
        sum  = SUM_W'(coef);
        for (int i = 0; i < NI; i++) begin
            coef = coefs_int[i*INT_COEF_W +: INT_COEF_W];
            xval = ints[i*INT_VAR_W +: INT_VAR_W];
            prod = PROD_W'(coef) * PROD_W'(xval);
            sum  = sum + SUM_W'(prod);
        end
    end

    always_comb begin
        bool_true = 1'b0;
        code      = BOOL_ABSENT;
        for (int j = 0; j < NB; j++) begin
            code = coefs_bool[2*j +: 2];
            if ((code == BOOL_POS && bools[j]) || (code == BOOL_NEG && !bools[j]))
                bool_true = 1'b1;
        end
    end

    assign int_true  = sum[SUM_W-1] || (sum == '0);
    assign satisfied = int_true || bool_true;

endmodule

// File: rtl/formula_checker_seq.sv
// Time-multiplexed formula checker: one clause per cycle through a read stage
// and an evaluate/accumulate stage. Optional FORMULA_CHECKER_EARLY_EXIT_EN stops
// at the first unsatisfied clause.
module formula_checker_seq
    import formula_checker_pkg::*;
#(
    parameter int INT_COEF_W     = 4,
    parameter int INT_VAR_IDX_W  = 1,
    parameter int BOOL_VAR_IDX_W = 1,
    parameter int INT_VAR_W      = 4,
    parameter int CLAUSE_IDX_W   = 2
) (
    input  logic                                                 in_clk,
    input  logic                                                 in_reset,
    input  logic                                                 in_write_enable,
    input  logic [CLAUSE_IDX_W-1:0]                              in_clause_index,
    input  logic [((1 << INT_VAR_IDX_W) + 1) * INT_COEF_W - 1:0] in_clause_coefficients_integer,
    input  logic [2 * (1 << BOOL_VAR_IDX_W) - 1:0]               in_clause_coefficients_boolean,
    input  logic [(1 << CLAUSE_IDX_W) - 1:0]                     in_clause_enable,
    input  logic [(1 << INT_VAR_IDX_W) * INT_VAR_W - 1:0]        in_integer_assignment_after_move,
    input  logic [(1 << BOOL_VAR_IDX_W) - 1:0]                   in_boolean_assignment_after_move,
    input  logic                                                 in_start,
    output logic                                                 out_busy,
    output logic                                                 out_done,
    output logic [(1 << CLAUSE_IDX_W) - 1:0]                     out_all_satisfied,
    output logic                                                 out_satisfied,
    output logic [CLAUSE_IDX_W:0]                                out_unsat_count
);

    localparam int NI = 1 << INT_VAR_IDX_W;
    localparam int NB = 1 << BOOL_VAR_IDX_W;
    localparam int NC = 1 << CLAUSE_IDX_W;
    localparam int CI_W = (NI + 1) * INT_COEF_W;
    localparam int CB_W = 2 * NB;
    localparam logic [CLAUSE_IDX_W-1:0] LAST_IDX = CLAUSE_IDX_W'(NC - 1);

    logic [CI_W-1:0]         coef_int_mem  [NC];
    logic [CB_W-1:0]         coef_bool_mem [NC];
    logic [NC-1:0]           en_snap;
    logic [NI*INT_VAR_W-1:0] ints_snap;
    logic [NB-1:0]           bools_snap;

    state_t                  state;
    logic [CLAUSE_IDX_W-1:0] idx;

    logic                    vld_p1;
    logic [CLAUSE_IDX_W-1:0] idx_p1;
    logic [CI_W-1:0]         ci_p1;
    logic [CB_W-1:0]         cb_p1;
    logic                    en_p1;

    logic                    vld_p2;
    logic                    last_p2;

    logic                    start_acc;
    logic                    eval_sat;
    logic                    clause_sat;
    logic                    in_flight;
    logic                    early_exit;
    logic                    result_we;

    assign start_acc = in_start && !out_busy;
    assign in_flight = (state == ST_RUN) || (state == ST_DRAIN);

`ifdef FORMULA_CHECKER_EARLY_EXIT_EN
    logic unsat_p2;

    always_ff @(posedge in_clk) begin
        if (in_reset)
            unsat_p2 <= 1'b0;
        else if (result_we)
            unsat_p2 <= !clause_sat;
    end

    assign early_exit = in_flight && vld_p2 && unsat_p2;
`else
    assign early_exit = 1'b0;
`endif

    // Clauses already in the pipeline when the run ends are dropped here
    assign result_we = vld_p1 && in_flight && !early_exit;

    // Storage, snapshots and stage 0 -> p1 read: data only, never reset
    always_ff @(posedge in_clk) begin
        if (in_write_enable && !out_busy) begin
            coef_int_mem[in_clause_index]  <= in_clause_coefficients_integer;
            coef_bool_mem[in_clause_index] <= in_clause_coefficients_boolean;
        end
        if (start_acc) begin
            ints_snap  <= in_integer_assignment_after_move;
            bools_snap <= in_boolean_assignment_after_move;
        end
        idx_p1 <= idx;
        ci_p1  <= coef_int_mem[idx];
        cb_p1  <= coef_bool_mem[idx];
        en_p1  <= en_snap[idx];
    end

    // p1 -> p2: evaluate and accumulate
    clause_evaluator #(
        .INT_COEF_W     (INT_COEF_W),
        .INT_VAR_IDX_W  (INT_VAR_IDX_W),
        .BOOL_VAR_IDX_W (BOOL_VAR_IDX_W),
        .INT_VAR_W      (INT_VAR_W)
    ) u_eval (
        .coefs_int  (ci_p1),
        .coefs_bool (cb_p1),
        .ints       (ints_snap),
        .bools      (bools_snap),
        .satisfied  (eval_sat)
    );

    assign clause_sat = !en_p1 || eval_sat;

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state             <= ST_IDLE;
            idx               <= '0;
            vld_p1            <= 1'b0;
            vld_p2            <= 1'b0;
            last_p2           <= 1'b0;
            en_snap           <= '0;
            out_busy          <= 1'b0;
            out_done          <= 1'b0;
            out_all_satisfied <= '0;
            out_satisfied     <= 1'b0;
            out_unsat_count   <= '0;
        end else begin
            out_done <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;

            if (result_we) begin
                out_all_satisfied[idx_p1] <= clause_sat;
                if (!clause_sat)
                    out_unsat_count <= out_unsat_count + 1'b1;
                vld_p2  <= 1'b1;
                last_p2 <= (idx_p1 == LAST_IDX);
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_start) begin
                        state             <= ST_RUN;
                        idx               <= '0;
                        en_snap           <= in_clause_enable;
                        out_busy          <= 1'b1;
                        out_all_satisfied <= '0;
                        out_satisfied     <= 1'b0;
                        out_unsat_count   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    vld_p1 <= 1'b1;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (vld_p2 && last_p2) begin
                        state         <= ST_DONE;
                        out_busy      <= 1'b0;
                        out_done      <= 1'b1;
                        out_satisfied <= &out_all_satisfied;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (early_exit) begin
                state         <= ST_DONE;
                vld_p1        <= 1'b0;
                out_busy      <= 1'b0;
                out_done      <= 1'b1;
                out_satisfied <= &out_all_satisfied;
            end
        end
    end

endmodule

// File: tb/tb_formula_checker_seq.sv
// Directed self-checking bench for formula_checker_seq (NI=2, NB=2, NC=4).
module tb_formula_checker_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  cidx;
    logic [11:0] ci;
    logic [3:0]  cb;
    logic [3:0]  en;
    logic [7:0]  ints;
    logic [1:0]  bools;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  all_sat;
    logic        sat;
    logic [2:0]  cnt;

    int tests = 0;
    int fails = 0;

`ifdef FORMULA_CHECKER_EARLY_EXIT_EN
    localparam int         MULTI_LAT = 4;
    localparam logic [3:0] MULTI_ALL = 4'b0001;
    localparam logic [2:0] MULTI_CNT = 3'd1;
`else
    localparam int         MULTI_LAT = 6;
    localparam logic [3:0] MULTI_ALL = 4'b1001;
    localparam logic [2:0] MULTI_CNT = 3'd2;
`endif

    always #5 clk = ~clk;

    formula_checker_seq dut (
        .in_clk                           (clk),
        .in_reset                         (rst),
        .in_write_enable                  (we),
        .in_clause_index                  (cidx),
        .in_clause_coefficients_integer   (ci),
        .in_clause_coefficients_boolean   (cb),
        .in_clause_enable                 (en),
        .in_integer_assignment_after_move (ints),
        .in_boolean_assignment_after_move (bools),
        .in_start                         (start),
        .out_busy                         (busy),
        .out_done                         (done),
        .out_all_satisfied                (all_sat),
        .out_satisfied                    (sat),
        .out_unsat_count                  (cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input logic [1:0] s, input logic [11:0] c, input logic [3:0] b);
        we = 1'b1; cidx = s; ci = c; cb = b;
        tick();
        we = 1'b0;
    endtask

    // Returns edges from the accepting edge to the done pulse (40 = never seen)
    task automatic start_and_wait(output int l);
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 0;
        while (done !== 1'b1 && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%0b exp=0", done); end
        tests++; if (all_sat !== 4'b0000) begin fails++; $display("FAIL reset_all_sat got=%b exp=0000", all_sat); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat got=%0b exp=0", sat); end
        tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        rst = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) write_slot(2'(s), 12'hC00, 4'b0000);
    endtask

    task automatic test_basic_sat();
        write_slot(2'd0, 12'hC11, 4'b0000);
        en = 4'b0001; ints = 8'h11; bools = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_k got=%0b exp=1", busy); end
        repeat (5) tick();
        tests++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL basic_k5 busy_done got=%b exp=10", {busy, done}); end
        tick();
        tests++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL basic_k6 busy_done got=%b exp=01", {busy, done}); end
        tests++; if (all_sat !== 4'b1111) begin fails++; $display("FAIL basic_all_sat got=%b exp=1111", all_sat); end
        tests++; if (sat !== 1'b1) begin fails++; $display("FAIL basic_sat got=%0b exp=1", sat); end
        tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL basic_count got=%0d exp=0", cnt); end
        tick();
        tests++; if ({done, all_sat, sat} !== 6'b0_1111_1) begin fails++; $display("FAIL basic_hold got=%b exp=011111", {done, all_sat, sat}); end
    endtask

    task automatic test_unsat();
        int l;
        write_slot(2'd0, 12'h411, 4'b1100);
        en = 4'b0001; ints = 8'h11; bools = 2'b10;
        start_and_wait(l);
        tests++; if (l !== 6) begin fails++; $display("FAIL unsat_latency got=%0d exp=6", l); end
        tests++; if (all_sat !== 4'b1110) begin fails++; $display("FAIL unsat_all_sat got=%b exp=1110", all_sat); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL unsat_sat got=%0b exp=0", sat); end
        tests++; if (cnt !== 3'd1) begin fails++; $display("FAIL unsat_count got=%0d exp=1", cnt); end
    endtask

    // Integer part of 12'h411 is always false (sum 6), so the boolean code decides
    task automatic test_boolean_codes();
        logic [3:0] v_cb  [5] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001, 4'b1000};
        logic [1:0] v_b   [5] = '{2'b01,   2'b01,   2'b00,   2'b01,   2'b10};
        logic       v_exp [5] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
        int l;
        en = 4'b0001; ints = 8'h11;
        for (int v = 0; v < 5; v++) begin
            write_slot(2'd0, 12'h411, v_cb[v]);
            bools = v_b[v];
            start_and_wait(l);
            tests++;
            if (all_sat[0] !== v_exp[v] || l !== 6)
                begin fails++; $display("FAIL bool_code_%0d sat0=%0b lat=%0d exp sat0=%0b lat=6", v, all_sat[0], l, v_exp[v]); end
        end
    endtask

    task automatic test_int_boundary();
        int l;
        en = 4'b0001; bools = 2'b00;
        write_slot(2'd0, 12'h888, 4'b0000);
        ints = 8'h88;
        start_and_wait(l);
        tests++; if ({all_sat, cnt} !== {4'b1110, 3'd1}) begin fails++; $display("FAIL no_overflow_120 got=%b/%0d exp=1110/1", all_sat, cnt); end
        write_slot(2'd0, 12'hE11, 4'b0000);
        ints = 8'h11;
        start_and_wait(l);
        tests++; if ({all_sat, cnt, sat} !== {4'b1111, 3'd0, 1'b1}) begin fails++; $display("FAIL sum_zero got=%b/%0d/%0b exp=1111/0/1", all_sat, cnt, sat); end
        write_slot(2'd0, 12'h777, 4'b0000);
        ints = 8'h88;
        start_and_wait(l);
        tests++; if ({all_sat, cnt} !== {4'b1111, 3'd0}) begin fails++; $display("FAIL sum_neg105 got=%b/%0d exp=1111/0", all_sat, cnt); end
    endtask

    task automatic setup_multi();
        write_slot(2'd0, 12'hC11, 4'b0000);
        write_slot(2'd1, 12'h411, 4'b0000);
        write_slot(2'd2, 12'h411, 4'b0000);
        write_slot(2'd3, 12'hC11, 4'b0000);
        ints = 8'h11; bools = 2'b00;
    endtask

    task automatic test_multi_clause();
        int l;
        setup_multi();
        en = 4'b1111;
        start_and_wait(l);
        tests++; if (l !== MULTI_LAT) begin fails++; $display("FAIL multi_latency got=%0d exp=%0d", l, MULTI_LAT); end
        tests++; if (all_sat !== MULTI_ALL) begin fails++; $display("FAIL multi_all_sat got=%b exp=%b", all_sat, MULTI_ALL); end
        tests++; if ({cnt, sat} !== {MULTI_CNT, 1'b0}) begin fails++; $display("FAIL multi_count_sat got=%0d/%0b exp=%0d/0", cnt, sat, MULTI_CNT); end
        en = 4'b1001;
        start_and_wait(l);
        tests++; if ({l[3:0], all_sat, cnt, sat} !== {4'd6, 4'b1111, 3'd0, 1'b1})
            begin fails++; $display("FAIL multi_masked lat=%0d all=%b cnt=%0d sat=%0b exp 6/1111/0/1", l, all_sat, cnt, sat); end
    endtask

    task automatic test_reset_midrun();
        int l;
        bit seen_done;
        en = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({busy, done, all_sat, sat, cnt} !== 10'b0)
            begin fails++; $display("FAIL midrun_reset got busy=%0b done=%0b all=%b sat=%0b cnt=%0d exp all 0", busy, done, all_sat, sat, cnt); end
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL midrun_stray_activity got=1 exp=0"); end
        start_and_wait(l);
        tests++; if ({l[3:0], all_sat, cnt} !== {4'(MULTI_LAT), MULTI_ALL, MULTI_CNT})
            begin fails++; $display("FAIL midrun_rerun lat=%0d all=%b cnt=%0d exp %0d/%b/%0d", l, all_sat, cnt, MULTI_LAT, MULTI_ALL, MULTI_CNT); end
    endtask

    task automatic test_busy_ignore();
        int l;
        bit extra_done;
        write_slot(2'd0, 12'h411, 4'b0000);
        en = 4'b0001; ints = 8'h11; bools = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; we = 1'b1; cidx = 2'd0; ci = 12'hC11; cb = 4'b0000;
        tick();
        start = 1'b0; we = 1'b0;
        l = 2;
        while (done !== 1'b1 && l < 40) begin
            tick();
            l++;
        end
        tests++; if (l !== 6) begin fails++; $display("FAIL busy_ignore_latency got=%0d exp=6", l); end
        tests++; if ({all_sat, cnt} !== {4'b1110, 3'd1}) begin fails++; $display("FAIL busy_ignore_result got=%b/%0d exp=1110/1", all_sat, cnt); end
        extra_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done === 1'b1) extra_done = 1'b1;
        end
        tests++; if (extra_done !== 1'b0) begin fails++; $display("FAIL busy_ignore_second_done got=1 exp=0"); end
        start_and_wait(l);
        tests++; if ({all_sat, cnt} !== {4'b1110, 3'd1}) begin fails++; $display("FAIL busy_ignore_slot_kept got=%b/%0d exp=1110/1", all_sat, cnt); end
    endtask

    task automatic test_back_to_back();
        int l;
        write_slot(2'd0, 12'hC11, 4'b0000);
        en = 4'b0001; ints = 8'h11; bools = 2'b00;
        start_and_wait(l);
        tests++; if ({all_sat, cnt} !== {4'b1111, 3'd0}) begin fails++; $display("FAIL b2b_first got=%b/%0d exp=1111/0", all_sat, cnt); end
        // Start in the done cycle, together with a write the new run must see
        we = 1'b1; cidx = 2'd0; ci = 12'h411; cb = 4'b0000;
        start_and_wait(l);
        we = 1'b0;
        tests++; if (l !== 6) begin fails++; $display("FAIL b2b_latency got=%0d exp=6", l); end
        tests++; if ({all_sat, cnt, sat} !== {4'b1110, 3'd1, 1'b0}) begin fails++; $display("FAIL b2b_write_seen got=%b/%0d/%0b exp=1110/1/0", all_sat, cnt, sat); end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; cidx = '0; ci = '0; cb = '0;
        en = '0; ints = '0; bools = '0; start = 1'b0;
        test_reset();
        test_basic_sat();
        test_unsat();
        test_boolean_codes();
        test_int_boundary();
        test_multi_clause();
        test_reset_midrun();
        test_busy_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
